// File: rtl/temp_disp_pkg.sv
// Shared types for the ADT7420 temperature display: FSM states, digit codes,
// the active-low 7-segment glyph table and the fraction scale factor.
package temp_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONVERT,
    ST_COMMIT
  } state_e;

  // Digit registers hold 0-9 directly; the two codes above 9 are glyph-only.
  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd11;

  // One raw LSB is 0.0625 C, i.e. 625 in units of 0.0001 C.
  localparam int unsigned FRAC_MULT = 625;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:      g = 7'h40;
      4'd1:      g = 7'h79;
      4'd2:      g = 7'h24;
      4'd3:      g = 7'h30;
      4'd4:      g = 7'h19;
      4'd5:      g = 7'h12;
      4'd6:      g = 7'h02;
      4'd7:      g = 7'h78;
      4'd8:      g = 7'h00;
      4'd9:      g = 7'h10;
      DIG_MINUS: g = 7'h3F;
      default:   g = 7'h7F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: a start pulse loads the value (performing the
// first shift), then one add-3/shift step per cycle; done holds until the next start.
module bin2bcd_seq #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [W-1:0]          value_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  done_o
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);

  logic [BW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [W-1:0]    bin_q, bin_d;
  logic [BW+W-1:0] shifted;
  logic [CW-1:0]   cnt_q;
  logic            done_q;

  // The BCD field is all zero at load time, so the first step is a bare shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    if (start_i) begin
      shifted = {{BW{1'b0}}, value_i} << 1;
    end else begin
      shifted = {bcd_adj, bin_q} << 1;
    end
    bcd_d = shifted[BW+W-1:W];
    bin_d = shifted[W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start_i) begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= CW'(1);
      done_q <= 1'b0;
    end else if (!done_q && cnt_q != '0) begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/adt7420_temp_display.sv
// ADT7420 word -> 8-digit 7-seg display (sign, 3 integer, 4 fraction digits), atomic
// digit update and digit scan. rst_n is active-HIGH. Optional alarm: `TEMP_ALARM_EN.
module adt7420_temp_display
  import temp_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int signed   ALARM_HI = 480,
  parameter int signed   ALARM_LO = 464
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temp_raw,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        temp_alarm
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e      state_q;
  logic [12:0] latched_q;
  logic        first_q;
  logic        busy_q;
  logic        sign_q;
  logic        mag_zero_q;
  logic [3:0]  digit_q [8];

  logic [12:0] raw13_in;
  logic [12:0] mag_in;
  logic [8:0]  int_in;
  logic [13:0] fdec_in;
  logic        conv_start;
  logic [11:0] int_bcd;
  logic [15:0] frac_bcd;
  logic        int_done, frac_done;
  logic [3:0]  hund, tens, ones;
  logic        alarm_lit;
  logic        unused_raw_bits;

  assign unused_raw_bits = ^temp_raw[2:0];

  // Two's-complement magnitude in 13 bits; -4096 maps to 4096 (256.0 C).
  assign raw13_in   = temp_raw[15:3];
  assign mag_in     = raw13_in[12] ? (13'd0 - raw13_in) : raw13_in;
  assign int_in     = mag_in[12:4];
  assign fdec_in    = 14'(mag_in[3:0] * FRAC_MULT);
  assign conv_start = (state_q == ST_LOAD);

  bin2bcd_seq #(.W(9), .DIGITS(3)) u_int_bcd (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (conv_start),
    .value_i (int_in),
    .bcd_o   (int_bcd),
    .done_o  (int_done)
  );

  bin2bcd_seq #(.W(14), .DIGITS(4)) u_frac_bcd (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (conv_start),
    .value_i (fdec_in),
    .bcd_o   (frac_bcd),
    .done_o  (frac_done)
  );

  assign hund = int_bcd[11:8];
  assign tens = int_bcd[7:4];
  assign ones = int_bcd[3:0];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      latched_q  <= '0;
      first_q    <= 1'b1;
      busy_q     <= 1'b0;
      sign_q     <= 1'b0;
      mag_zero_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        digit_q[i] <= DIG_BLANK;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (first_q || raw13_in != latched_q) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          latched_q  <= raw13_in;
          first_q    <= 1'b0;
          sign_q     <= raw13_in[12];
          mag_zero_q <= (mag_in == '0);
          state_q    <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (int_done && frac_done) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // All eight digits are written together so the display never tears.
          digit_q[7] <= (sign_q && !mag_zero_q) ? DIG_MINUS : DIG_BLANK;
          digit_q[6] <= (hund == 4'd0) ? DIG_BLANK : hund;
          digit_q[5] <= (hund == 4'd0 && tens == 4'd0) ? DIG_BLANK : tens;
          digit_q[4] <= ones;
          digit_q[3] <= frac_bcd[15:12];
          digit_q[2] <= frac_bcd[11:8];
          digit_q[1] <= frac_bcd[7:4];
          digit_q[0] <= frac_bcd[3:0];
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;

`ifdef TEMP_ALARM_EN
  localparam logic signed [12:0] ALARM_HI_S = 13'(ALARM_HI);
  localparam logic signed [12:0] ALARM_LO_S = 13'(ALARM_LO);

  logic signed [12:0] raw13_q;
  logic               alarm_q;

  assign raw13_q = latched_q;

  // Hysteresis band between the two levels holds the previous state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      alarm_q <= 1'b0;
    end else if (state_q == ST_COMMIT) begin
      if (raw13_q >= ALARM_HI_S) begin
        alarm_q <= 1'b1;
      end else if (raw13_q < ALARM_LO_S) begin
        alarm_q <= 1'b0;
      end
    end
  end

  assign temp_alarm = alarm_q;
  assign alarm_lit  = alarm_q;
`else
  logic [12:0] unused_alarm_cfg;

  assign unused_alarm_cfg = 13'(ALARM_HI) ^ 13'(ALARM_LO);
  assign temp_alarm       = 1'b0;
  assign alarm_lit        = 1'b0;
`endif

  logic [DIV_W-1:0] div_q;
  logic [2:0]       idx_q;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= '1;
      dp_q  <= 1'b1;
    end else begin
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      an_q  <= ~(8'd1 << idx_q);
      seg_q <= seg7_glyph(digit_q[idx_q]);
      dp_q  <= ~((idx_q == 3'd4) || (alarm_lit && idx_q == 3'd0));
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
